// File: rtl/FIFO_shared_pkg.sv
// Shared definitions for the FIFO read side: word width, FIFO depth and
// the read-controller state encoding.
package FIFO_shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_HOLD  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered skid buffer. Entry 0 is the head and is driven
// straight from a register, so the head word only moves on a pop.
module fifo_skid_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic             push_ok;
    logic             pop_ok;
    logic [1:0]       occ_next;

    // A full buffer only accepts a push when it is popped in the same cycle.
    assign push_ok = push & ((occ != 2'd2) | pop);
    assign pop_ok  = pop & (occ != 2'd0);

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_next = occ;
        if (push_ok && !pop_ok) begin
            occ_next = occ + 2'd1;
        end else if (pop_ok && !push_ok) begin
            occ_next = occ - 2'd1;
        end
    end

    // Entry storage, occupancy and the registered valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            occ   <= 2'd0;
            valid <= 1'b0;
        end else begin
            occ   <= occ_next;
            valid <= (occ_next != 2'd0);
            if (pop_ok) begin
                if (push_ok && occ == 2'd1) begin
                    ent0 <= din;
                end else begin
                    ent0 <= ent1;
                end
                if (push_ok && occ == 2'd2) begin
                    ent1 <= din;
                end
            end else if (push_ok) begin
                if (occ == 2'd0) begin
                    ent0 <= din;
                end else begin
                    ent1 <= din;
                end
            end
        end
    end

    assign head = ent0;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: issues reads against a synchronous FIFO, tracks the
// one-cycle read latency, parks returned words in a 2-entry skid buffer and
// counts words delivered downstream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | disabled, or nothing buffered, in flight or in the FIFO
// FETCH    | reads permitted while there is room
// HOLD     | buffer plus in-flight word fill both slots, nothing popped
module fifo_rd_ctrl #(
    parameter int FIFO_WIDTH = FIFO_shared_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err_underflow
);

    import FIFO_shared_pkg::*;

    localparam logic [1:0] ST_IDLE  = RD_IDLE;
    localparam logic [1:0] ST_FETCH = RD_FETCH;
    localparam logic [1:0] ST_HOLD  = RD_HOLD;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       inflight_q;
    logic [1:0] occ;
    logic [2:0] load;
    logic       pop;
    logic       push;

    assign pop  = m_valid & m_ready;
    assign load = {1'b0, occ} + {2'b0, inflight_q};

    // Room check is written as load < 2 + pop to avoid an unsigned wrap.
    assign fifo_rd_en = en & ~fifo_empty & ~rst & (load < (3'd2 + {2'b0, pop}));

    // An underflowed read returns garbage, so it is never pushed.
    assign push = inflight_q & ~fifo_underflow;

    fifo_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_data_out),
        .pop   (pop),
        .head  (m_data),
        .valid (m_valid),
        .occ   (occ)
    );

    // Classify the current cycle; the result is registered as the state.
    always_comb begin
        state_d = ST_FETCH;
        if (!en || (fifo_empty && occ == 2'd0 && !inflight_q)) begin
            state_d = ST_IDLE;
        end else if (load == 3'd2 && !pop) begin
            state_d = ST_HOLD;
        end
    end

    // State, in-flight tracking, delivered-word counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            inflight_q    <= 1'b0;
            rd_count      <= '0;
            err_underflow <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= fifo_rd_en;
            rd_count      <= rd_count + CNT_WIDTH'(pop);
            err_underflow <= err_underflow | (inflight_q & fifo_underflow);
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small synchronous FIFO model whose
// active-low reset is tied to ~rst.
module tb_fifo_rd_ctrl;

    import FIFO_shared_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        m_ready = 1'b0;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        err_underflow;
    logic [15:0] fifo_data_out;
    logic [15:0] m_data;
    logic [15:0] rd_count;

    int checks = 0;
    int errors = 0;

    // FIFO model
    logic        fifo_rst_n;
    logic [15:0] mem [FIFO_DEPTH];
    logic [3:0]  cnt;
    logic [2:0]  wp;
    logic [2:0]  rp;
    logic        uf_q;
    logic        wr_req = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        feed = 1'b0;
    logic [15:0] feed_val;
    logic        force_uf = 1'b0;
    logic        wr_do;
    logic        rd_do;
    logic [15:0] wr_val;

    assign fifo_rst_n     = ~rst;
    assign fifo_empty     = (cnt == 4'd0);
    assign fifo_underflow = uf_q | force_uf;
    assign wr_val         = feed ? feed_val : wr_data;
    assign wr_do          = (feed | wr_req) & (cnt < 4'd8);
    assign rd_do          = fifo_rd_en & (cnt != 4'd0);

    always #5 clk = ~clk;

    // Synchronous FIFO with registered read data and underflow flag.
    always @(posedge clk) begin
        if (!fifo_rst_n) begin
            cnt           <= 4'd0;
            wp            <= 3'd0;
            rp            <= 3'd0;
            uf_q          <= 1'b0;
            fifo_data_out <= 16'h0;
            feed_val      <= 16'h0;
        end else begin
            if (wr_do) begin
                mem[wp] <= wr_val;
                wp      <= wp + 3'd1;
                if (feed) feed_val <= feed_val + 16'd1;
            end
            if (rd_do) begin
                fifo_data_out <= mem[rp];
                rp            <= rp + 3'd1;
            end
            uf_q <= fifo_rd_en & (cnt == 4'd0);
            cnt  <= cnt + 4'(wr_do) - 4'(rd_do);
        end
    end

    fifo_rd_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .rd_count       (rd_count),
        .err_underflow  (err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] w);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_req  = 1'b0;
    endtask

    logic [15:0] bp_exp [4] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    int nrd;
    int idx;
    bit reached;

    initial begin
        // Reset with three words in the FIFO
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr(16'h1111);
        wr(16'h2222);
        wr(16'h3333);
        rst = 1'b1;
        en  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_rd_count", 32'(rd_count), 32'd0);
            chk("rst_err", 32'(err_underflow), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        en  = 1'b0;

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) wr(16'(i));
        en      = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            chk("stream_rd_en", 32'(fifo_rd_en), 32'(c < 8));
            chk("stream_valid", 32'(m_valid), 32'(c >= 2 && c < 10));
            if (c >= 2 && c < 10) chk("stream_data", 32'(m_data), 32'(c - 1));
            @(negedge clk);
        end
        chk("stream_count", 32'(rd_count), 32'd8);
        chk("stream_empty", 32'(fifo_empty), 32'd1);
        en      = 1'b0;
        m_ready = 1'b0;

        // Backpressure
        for (int i = 0; i < 4; i++) wr(bp_exp[i]);
        en  = 1'b1;
        nrd = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (fifo_rd_en) nrd++;
            if (c >= 2) chk("bp_hold_data", 32'(m_data), 32'h00A1);
            @(negedge clk);
        end
        chk("bp_reads", 32'(nrd), 32'd2);
        chk("bp_state", 32'(dut.state_q), 32'(RD_HOLD));
        chk("bp_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (m_valid) begin
                if (idx < 4) chk("bp_order", 32'(m_data), 32'(bp_exp[idx]));
                idx++;
            end
            @(negedge clk);
        end
        chk("bp_delivered", 32'(idx), 32'd4);
        chk("bp_drained", 32'(m_valid), 32'd0);
        chk("bp_count", 32'(rd_count), 32'd12);
        en      = 1'b0;
        m_ready = 1'b0;

        // en drops right after a read is issued
        wr(16'h00B1);
        wr(16'h00B2);
        wr(16'h00B3);
        en      = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("endrop_first_rd", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        en  = 1'b0;
        nrd = 0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (fifo_rd_en) nrd++;
            if (m_valid) begin
                chk("endrop_data", 32'(m_data), 32'h00B1);
                idx++;
            end
            @(negedge clk);
        end
        chk("endrop_words", 32'(idx), 32'd1);
        chk("endrop_reads", 32'(nrd), 32'd0);
        chk("endrop_valid", 32'(m_valid), 32'd0);
        chk("endrop_fifo_left", 32'(fifo_empty), 32'd0);
        chk("endrop_count", 32'(rd_count), 32'd13);

        // Reset with two words buffered drops them
        en      = 1'b1;
        m_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_count", 32'(rd_count), 32'd0);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_deliver", 32'(rd_count), 32'd0);
        chk("midrst_no_valid", 32'(m_valid), 32'd0);
        en      = 1'b0;
        m_ready = 1'b0;

        // Underflow on the cycle after a read
        wr(16'h00C1);
        en      = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("uf_rd_en", 32'(fifo_rd_en), 32'd1);
        chk("uf_err_before", 32'(err_underflow), 32'd0);
        @(negedge clk);
        force_uf = 1'b1;
        en       = 1'b0;
        @(negedge clk);
        force_uf = 1'b0;
        chk("uf_err_set", 32'(err_underflow), 32'd1);
        chk("uf_discard", 32'(m_valid), 32'd0);
        chk("uf_count", 32'(rd_count), 32'd0);
        repeat (3) @(negedge clk);
        chk("uf_sticky", 32'(err_underflow), 32'd1);
        chk("uf_still_empty", 32'(m_valid), 32'd0);
        chk("uf_count_hold", 32'(rd_count), 32'd0);
        m_ready = 1'b0;

        // Counter wrap
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wrap_err_cleared", 32'(err_underflow), 32'd0);
        feed    = 1'b1;
        en      = 1'b1;
        m_ready = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            if (rd_count == 16'hFFFF) begin
                m_ready = 1'b0;
                reached = 1'b1;
                break;
            end
        end
        chk("wrap_reach", 32'(reached), 32'd1);
        @(negedge clk);
        chk("wrap_ffff", 32'(rd_count), 32'h0000FFFF);
        chk("wrap_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("wrap_zero", 32'(rd_count), 32'd0);
        feed = 1'b0;
        en   = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
